fft16: RTL and testbench
========================

Name: fft16

Overview:
- 16-point radix-2 decimation-in-time FFT over a parallel block of 16 real time-domain samples.
- Produces an approximate magnitude per frequency bin; sits between the sample-capture buffer and the spectrum display logic.
- Start/done handshake; one transform per start.

Parameters:
WIDTH, 18, bit width of each input sample; output magnitudes are WIDTH+1 bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  begin transform (level, sampled in IDLE or DONE)
done  output  1  high while freq_mag holds a valid result
time_samples  input  [WIDTH-1:0] x16 (unpacked [0:15])  unsigned real samples, index = time n
freq_mag  output  [WIDTH:0] x16 (unpacked [0:N-1])  magnitude of bin k, index = k

Behaviour:
- Reset (async, rst=1): state IDLE, done=0, all freq_mag=0, internal registers cleared. Reset mid-transform aborts it immediately.
- States:
  - IDLE: start=1 → LOAD.
  - LOAD: latch time_samples in bit-reversed order as real parts; imaginary parts = 0.
  - S1..S4: one butterfly stage per clock, 8 butterflies per stage.
  - MAG: compute magnitudes into freq_mag.
  - DONE: done=1.
- DONE → LOAD when start=1 on a clock edge; done drops that same edge. With start held high, transforms repeat back to back.
- start is ignored in LOAD, S1..S4 and MAG.
- Latency: start sampled at edge 0; freq_mag valid and done=1 after edge 6.
- time_samples are read only at the LOAD edge; later changes do not affect the transform in flight.
- freq_mag holds its last value until the next MAG write or reset.
- Arithmetic:
  - Samples zero-extended into signed internal words of WIDTH+6 bits; no per-stage scaling. 16×(2^WIDTH−1) must not overflow.
  - Twiddles W16^k = cos(2πk/16) − j·sin(2πk/16), k=0..7, as signed constants with 16 fractional bits, rounded to nearest.
  - Product rounded to nearest by adding 2^15 before the >>16 arithmetic shift.
  - W^0 is multiplier-free, so bins with zero imaginary part are exact.
- Magnitude: a=|re|, b=|im|, mx=max(a,b), mn=min(a,b); mag = mx + (mn>>2) + (mn>>3).
- Output saturation: mag saturates at 2^(WIDTH+1)−1 if it exceeds the output range.
- Spectrum symmetry: all 16 bins are output; for real input freq_mag[k] = freq_mag[16−k] for k=1..7.

Test Plan:
- Reset check: rst=1 → done=0 and every freq_mag=0; assert rst mid-transform → same state within the same cycle, no done.
- Reference block, WIDTH=18: samples {1061,235,3980,1096,3839,905,2763,3717,2895,960,144,129,4044,3655,2797,2556}, start held high.
  - done=1 six clocks after start.
  - freq_mag[0]=34776, freq_mag[8]=8270.
  - freq_mag[k]=freq_mag[16−k] for k=1..7.
- Impulse: x[0]=1000, others 0 → all 16 bins = 1000.
- DC: all samples 4095 → freq_mag[0]=65520, all other bins 0.
- Alternating 0/4000 (x[odd]=4000) → freq_mag[0]=32000, freq_mag[8]=32000, other bins 0.
- Handshake:
  - Change time_samples during S1..S4 → result unaffected.
  - start pulsed once → done stays high and freq_mag stable until the next start.
  - start held high → done deasserts for 6 cycles each repeat.

Source files
------------

// File: rtl/fft16.sv
// 16-point radix-2 decimation-in-time FFT over a parallel block of real samples,
// one butterfly stage per clock, then an alpha-max-beta-min magnitude per bin.
module fft16 #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             done,
    input  logic [WIDTH-1:0] time_samples [0:15],
    output logic [WIDTH:0]   freq_mag     [0:15]
);

    localparam int IW = WIDTH + 6;
    localparam int TW = 18;
    localparam int PW = IW + TW + 1;
    localparam logic [IW+1:0] MAG_MAX = (IW+2)'({(WIDTH+1){1'b1}});

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_S1   = 3'd2,
        ST_S2   = 3'd3,
        ST_S3   = 3'd4,
        ST_S4   = 3'd5,
        ST_MAG  = 3'd6,
        ST_DONE = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic signed [IW-1:0] r_re    [0:15];
    logic signed [IW-1:0] r_im    [0:15];
    logic signed [IW-1:0] w_bf_re [0:15];
    logic signed [IW-1:0] w_bf_im [0:15];
    logic [WIDTH:0]       r_mag   [0:15];
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 w_load;
    logic                 w_stage;
    logic                 w_mag_en;
    logic [1:0]           w_sh;
    logic [3:0]           w_top;
    logic [3:0]           w_bot;
    logic [2:0]           w_k;
    logic signed [IW-1:0] w_tr;
    logic signed [IW-1:0] w_ti;

    function automatic logic [3:0] f_bitrev(input logic [3:0] i_v);
        f_bitrev = {i_v[0], i_v[1], i_v[2], i_v[3]};
    endfunction

    // Twiddle W16^k = cos - j*sin, Q16 rounded to nearest
    function automatic logic signed [TW-1:0] f_wr(input logic [2:0] i_k);
        case (i_k)
            3'd0:    f_wr = 18'sd65536;
            3'd1:    f_wr = 18'sd60547;
            3'd2:    f_wr = 18'sd46341;
            3'd3:    f_wr = 18'sd25080;
            3'd4:    f_wr = 18'sd0;
            3'd5:    f_wr = -18'sd25080;
            3'd6:    f_wr = -18'sd46341;
            3'd7:    f_wr = -18'sd60547;
            default: f_wr = 18'sd0;
        endcase
    endfunction

    function automatic logic signed [TW-1:0] f_wi(input logic [2:0] i_k);
        case (i_k)
            3'd0:    f_wi = 18'sd0;
            3'd1:    f_wi = -18'sd25080;
            3'd2:    f_wi = -18'sd46341;
            3'd3:    f_wi = -18'sd60547;
            3'd4:    f_wi = -18'sd65536;
            3'd5:    f_wi = -18'sd60547;
            3'd6:    f_wi = -18'sd46341;
            3'd7:    f_wi = -18'sd25080;
            default: f_wi = 18'sd0;
        endcase
    endfunction

    function automatic logic signed [IW-1:0] f_cmul_re(input logic signed [IW-1:0] i_xr,
                                                        input logic signed [IW-1:0] i_xi,
                                                        input logic [2:0] i_k);
        logic signed [PW-1:0] v_p;
        if (i_k == 3'd0) begin
            v_p = PW'(i_xr) <<< 16;
        end else begin
            v_p = PW'(i_xr) * PW'(f_wr(i_k)) - PW'(i_xi) * PW'(f_wi(i_k));
        end
        v_p = v_p + PW'(32'sd32768);
        f_cmul_re = IW'(v_p >>> 16);
    endfunction

    function automatic logic signed [IW-1:0] f_cmul_im(input logic signed [IW-1:0] i_xr,
                                                        input logic signed [IW-1:0] i_xi,
                                                        input logic [2:0] i_k);
        logic signed [PW-1:0] v_p;
        if (i_k == 3'd0) begin
            v_p = PW'(i_xi) <<< 16;
        end else begin
            v_p = PW'(i_xr) * PW'(f_wi(i_k)) + PW'(i_xi) * PW'(f_wr(i_k));
        end
        v_p = v_p + PW'(32'sd32768);
        f_cmul_im = IW'(v_p >>> 16);
    endfunction

    // Butterfly b of stage sh: top index, span and twiddle exponent
    function automatic logic [3:0] f_top(input logic [1:0] i_sh, input logic [2:0] i_b);
        case (i_sh)
            2'd0:    f_top = {i_b, 1'b0};
            2'd1:    f_top = {i_b[2:1], 1'b0, i_b[0]};
            2'd2:    f_top = {i_b[2], 1'b0, i_b[1:0]};
            default: f_top = {1'b0, i_b};
        endcase
    endfunction

    function automatic logic [3:0] f_half(input logic [1:0] i_sh);
        case (i_sh)
            2'd0:    f_half = 4'd1;
            2'd1:    f_half = 4'd2;
            2'd2:    f_half = 4'd4;
            default: f_half = 4'd8;
        endcase
    endfunction

    function automatic logic [2:0] f_twk(input logic [1:0] i_sh, input logic [2:0] i_b);
        case (i_sh)
            2'd0:    f_twk = 3'd0;
            2'd1:    f_twk = {i_b[0], 2'b00};
            2'd2:    f_twk = {i_b[1:0], 1'b0};
            default: f_twk = i_b;
        endcase
    endfunction

    function automatic logic [WIDTH:0] f_mag(input logic signed [IW-1:0] i_re,
                                             input logic signed [IW-1:0] i_im);
        logic [IW-1:0] v_a;
        logic [IW-1:0] v_b;
        logic [IW-1:0] v_mx;
        logic [IW-1:0] v_mn;
        logic [IW+1:0] v_sum;
        v_a = i_re[IW-1] ? -i_re : i_re;
        v_b = i_im[IW-1] ? -i_im : i_im;
        if (v_a >= v_b) begin
            v_mx = v_a;
            v_mn = v_b;
        end else begin
            v_mx = v_b;
            v_mn = v_a;
        end
        v_sum = {2'b00, v_mx} + {2'b00, v_mn >> 2} + {2'b00, v_mn >> 3};
        f_mag = (v_sum > MAG_MAX) ? {(WIDTH+1){1'b1}} : (WIDTH+1)'(v_sum);
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = start ? ST_LOAD : ST_IDLE;
            ST_LOAD: w_state_nxt = ST_S1;
            ST_S1:   w_state_nxt = ST_S2;
            ST_S2:   w_state_nxt = ST_S3;
            ST_S3:   w_state_nxt = ST_S4;
            ST_S4:   w_state_nxt = ST_MAG;
            ST_MAG:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = start ? ST_LOAD : ST_DONE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: datapath enables and next value of done
    always_comb begin
        w_load     = 1'b0;
        w_stage    = 1'b0;
        w_mag_en   = 1'b0;
        w_done_nxt = 1'b0;
        w_sh       = 2'd0;
        case (r_state)
            ST_LOAD: w_load = 1'b1;
            ST_S1:   begin w_stage = 1'b1; w_sh = 2'd0; end
            ST_S2:   begin w_stage = 1'b1; w_sh = 2'd1; end
            ST_S3:   begin w_stage = 1'b1; w_sh = 2'd2; end
            ST_S4:   begin w_stage = 1'b1; w_sh = 2'd3; end
            ST_MAG:  begin w_mag_en = 1'b1; w_done_nxt = 1'b1; end
            ST_DONE: w_done_nxt = ~start;
            default: w_done_nxt = 1'b0;
        endcase
    end

    // Eight butterflies of the current stage
    always_comb begin
        w_top = 4'd0;
        w_bot = 4'd0;
        w_k   = 3'd0;
        w_tr  = '0;
        w_ti  = '0;
        for (int i = 0; i < 16; i++) begin
            w_bf_re[i] = r_re[i];
            w_bf_im[i] = r_im[i];
        end
        for (int b = 0; b < 8; b++) begin
            w_top = f_top(w_sh, 3'(b));
            w_bot = w_top | f_half(w_sh);
            w_k   = f_twk(w_sh, 3'(b));
            w_tr  = f_cmul_re(r_re[w_bot], r_im[w_bot], w_k);
            w_ti  = f_cmul_im(r_re[w_bot], r_im[w_bot], w_k);
            w_bf_re[w_top] = r_re[w_top] + w_tr;
            w_bf_im[w_top] = r_im[w_top] + w_ti;
            w_bf_re[w_bot] = r_re[w_top] - w_tr;
            w_bf_im[w_bot] = r_im[w_top] - w_ti;
        end
    end

    // Working registers: bit-reversed load, stage update, magnitude capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_re[i]  <= '0;
                r_im[i]  <= '0;
                r_mag[i] <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < 16; i++) begin
                r_re[i] <= {{(IW-WIDTH){1'b0}}, time_samples[f_bitrev(4'(i))]};
                r_im[i] <= '0;
            end
        end else if (w_stage) begin
            for (int i = 0; i < 16; i++) begin
                r_re[i] <= w_bf_re[i];
                r_im[i] <= w_bf_im[i];
            end
        end else if (w_mag_en) begin
            for (int i = 0; i < 16; i++) begin
                r_mag[i] <= f_mag(r_re[i], r_im[i]);
            end
        end
    end

    // Done flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
        end
    end

    assign done     = r_done;
    assign freq_mag = r_mag;

endmodule

// File: tb/tb_fft16.sv
// Scoreboard bench for fft16: a plain-arithmetic FFT reference model pushes expected
// spectra, a negedge monitor pops and compares them whenever done rises.
module tb_fft16;

    localparam int WIDTH = 18;
    localparam int MW    = WIDTH + 1;
    localparam longint MAGMAX = (longint'(1) << MW) - 1;
    localparam real PI = 3.14159265358979323846;

    typedef logic [16*MW-1:0] spec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             done;
    logic [WIDTH-1:0] time_samples [0:15];
    logic [WIDTH:0]   freq_mag     [0:15];

    int     n_tests = 0;
    int     n_fail  = 0;
    spec_t  exp_q[$];
    spec_t  last_exp;
    longint tw_re [0:7];
    longint tw_im [0:7];
    logic [WIDTH-1:0] blk [0:15];
    int     lat;

    fft16 #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .done(done),
        .time_samples(time_samples),
        .freq_mag(freq_mag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Textbook iterative radix-2 FFT on integers, then the magnitude approximation
    function automatic spec_t model(input logic [WIDTH-1:0] x [0:15]);
        longint re [0:15];
        longint im [0:15];
        longint tr, ti, ur, ui, a, b, mx, mn, m;
        int     r, k, t, u;
        spec_t  res;
        for (int i = 0; i < 16; i++) begin
            r = 0;
            for (int bit_i = 0; bit_i < 4; bit_i++)
                if (((i >> bit_i) & 1) == 1) r = r | (1 << (3 - bit_i));
            re[i] = longint'(x[r]);
            im[i] = 0;
        end
        for (int half = 1; half < 16; half = half * 2) begin
            for (int g = 0; g < 16; g = g + 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    k  = j * 8 / half;
                    t  = g + j;
                    u  = t + half;
                    tr = (re[u] * tw_re[k] - im[u] * tw_im[k] + 32768) >>> 16;
                    ti = (re[u] * tw_im[k] + im[u] * tw_re[k] + 32768) >>> 16;
                    ur = re[t];
                    ui = im[t];
                    re[t] = ur + tr;
                    im[t] = ui + ti;
                    re[u] = ur - tr;
                    im[u] = ui - ti;
                end
            end
        end
        res = '0;
        for (int i = 0; i < 16; i++) begin
            a  = (re[i] < 0) ? -re[i] : re[i];
            b  = (im[i] < 0) ? -im[i] : im[i];
            mx = (a > b) ? a : b;
            mn = (a > b) ? b : a;
            m  = mx + mn / 4 + mn / 8;
            if (m > MAGMAX) m = MAGMAX;
            res[i*MW +: MW] = MW'(m);
        end
        return res;
    endfunction

    // Start one transform from IDLE/DONE and measure start-to-done latency
    task automatic do_xform(input bit keep);
        int l;
        @(negedge clk);
        for (int i = 0; i < 16; i++) time_samples[i] = blk[i];
        last_exp = model(blk);
        exp_q.push_back(last_exp);
        start = 1'b1;
        l = -1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 0 && !keep) start = 1'b0;
            if (e == 1)
                for (int i = 0; i < 16; i++) time_samples[i] = WIDTH'($urandom);
            if (done) begin
                l = e;
                break;
            end
        end
        lat = l;
        check("latency", lat, 6);
    endtask

    // Monitor: compare against the scoreboard on every rising done
    initial begin : monitor
        logic  prev;
        spec_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && !prev) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
                end else begin
                    e = exp_q.pop_front();
                    for (int k = 0; k < 16; k++)
                        check($sformatf("bin%0d", k), longint'(freq_mag[k]), longint'(e[k*MW +: MW]));
                end
            end
            prev = done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        for (int k = 0; k < 8; k++) begin
            tw_re[k] = longint'($rtoi($floor(65536.0 * $cos(2.0 * PI * k / 16.0) + 0.5)));
            tw_im[k] = longint'($rtoi($floor(-65536.0 * $sin(2.0 * PI * k / 16.0) + 0.5)));
        end
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) time_samples[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        for (int k = 0; k < 16; k++) check("rst_bin", freq_mag[k], 0);
        @(negedge clk);
        rst = 1'b0;

        blk = '{18'd1061, 18'd235, 18'd3980, 18'd1096, 18'd3839, 18'd905, 18'd2763, 18'd3717,
                18'd2895, 18'd960, 18'd144, 18'd129, 18'd4044, 18'd3655, 18'd2797, 18'd2556};
        do_xform(1'b1);
        check("ref_bin0", freq_mag[0], 34776);
        check("ref_bin8", freq_mag[8], 8270);
        for (int k = 1; k < 8; k++) check($sformatf("ref_sym%0d", k), freq_mag[k], freq_mag[16-k]);

        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0] = 18'd1000;
        do_xform(1'b1);
        for (int k = 0; k < 16; k++) check("impulse", freq_mag[k], 1000);

        for (int i = 0; i < 16; i++) blk[i] = 18'd4095;
        do_xform(1'b1);
        for (int k = 0; k < 16; k++) check("dc", freq_mag[k], (k == 0) ? 65520 : 0);

        for (int i = 0; i < 16; i++) blk[i] = (i % 2 == 1) ? 18'd4000 : 18'd0;
        do_xform(1'b0);
        for (int k = 0; k < 16; k++) check("alt", freq_mag[k], (k == 0 || k == 8) ? 32000 : 0);

        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_done", done, 1);
            for (int k = 0; k < 16; k++)
                check("hold_bin", longint'(freq_mag[k]), longint'(last_exp[k*MW +: MW]));
        end

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 16; i++)
                blk[i] = (n % 3 == 0) ? WIDTH'($urandom_range(0, 4095)) : WIDTH'($urandom);
            do_xform(1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 16; i++) blk[i] = {WIDTH{1'b1}};
        do_xform(1'b0);
        check("sat_bin0", freq_mag[0], MAGMAX);

        @(negedge clk);
        for (int i = 0; i < 16; i++) time_samples[i] = WIDTH'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_done", done, 0);
        for (int k = 0; k < 16; k++) check("abort_bin", freq_mag[k], 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", done, 0);
        end

        for (int i = 0; i < 16; i++) blk[i] = WIDTH'($urandom);
        do_xform(1'b0);

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
